// File: rtl/gfx256_pkg.sv
// +-----------------------------------------------------------------------+
// | gfx256_pkg : shared types, constants and helpers for the gfx256 pipe  |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package gfx256_pkg;

  typedef enum logic [2:0] {
    ZB_WAIT    = 3'd0,
    ZB_ADDR    = 3'd1,
    ZB_READ    = 3'd2,
    ZB_TEST    = 3'd3,
    ZB_ZWRITE  = 3'd4,
    ZB_FORWARD = 3'd5,
    ZB_DONE    = 3'd6
  } zbuf_state_t;

  localparam int         ZBUF_BYTES_PER_PIXEL = 2;
  localparam logic [1:0] ZBUF_BPP_SHIFT       = 2'($clog2(ZBUF_BYTES_PER_PIXEL));

  // Larger z is nearer; equal depth is treated as occluded.
  function automatic logic depth_pass(input logic signed [15:0] z_new,
                                      input logic signed [15:0] z_old);
    return z_new > z_old;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gfx256_pixel_addr.sv
// +-----------------------------------------------------------------------+
// | gfx256_pixel_addr : base + ((y*width + x) << bpp_shift), 32-bit wrap  |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module gfx256_pixel_addr #(
  parameter int PW = 16
) (
  input  logic [31:0]   base_i,
  input  logic [PW-1:0] x_i,
  input  logic [PW-1:0] y_i,
  input  logic [PW-1:0] width_i,
  input  logic [1:0]    bpp_shift_i,
  output logic [31:0]   addr_o
);

  logic [31:0] pix_index;

  assign pix_index = 32'(y_i) * 32'(width_i) + 32'(x_i);
  assign addr_o    = base_i + (pix_index << bpp_shift_i);

endmodule

`default_nettype wire

// File: rtl/gfx256_zbuffer_test.sv
// +-----------------------------------------------------------------------+
// | gfx256_zbuffer_test : depth test between interpolator and blender     |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module gfx256_zbuffer_test
  import gfx256_pkg::*;
#(
  parameter int POINT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   zbuf_enable_i,
  input  logic [31:0]            zbuf_base_i,
  input  logic [POINT_WIDTH-1:0] target_size_x_i,
  input  logic                   write_i,
  output logic                   ack_o,
  input  logic [POINT_WIDTH-1:0] x_i,
  input  logic [POINT_WIDTH-1:0] y_i,
  input  logic [POINT_WIDTH-1:0] z_i,
  input  logic [31:0]            color_i,
  input  logic [POINT_WIDTH-1:0] u_i,
  input  logic [POINT_WIDTH-1:0] v_i,
  input  logic [7:0]             a_i,
  output logic [POINT_WIDTH-1:0] x_o,
  output logic [POINT_WIDTH-1:0] y_o,
  output logic [POINT_WIDTH-1:0] z_o,
  output logic [31:0]            color_o,
  output logic [POINT_WIDTH-1:0] u_o,
  output logic [POINT_WIDTH-1:0] v_o,
  output logic [7:0]             a_o,
  output logic                   write_o,
  input  logic                   ack_i,
  output logic                   zr_request_o,
  output logic [31:0]            zr_addr_o,
  input  logic [31:0]            zr_data_i,
  input  logic                   zr_ack_i,
  output logic                   zw_request_o,
  output logic [31:0]            zw_addr_o,
  output logic [31:0]            zw_data_o,
  output logic [3:0]             zw_sel_o,
  input  logic                   zw_ack_i
);

  zbuf_state_t state_q;
  logic        half_q;
  logic [15:0] depth_q;
  logic [31:0] zaddr_d;
  logic        unused_zaddr_bit0;

  gfx256_pixel_addr #(.PW(POINT_WIDTH)) u_pixel_addr (
    .base_i      (zbuf_base_i),
    .x_i         (x_o),
    .y_i         (y_o),
    .width_i     (target_size_x_i),
    .bpp_shift_i (ZBUF_BPP_SHIFT),
    .addr_o      (zaddr_d)
  );

  assign unused_zaddr_bit0 = zaddr_d[0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ZB_WAIT;
      half_q       <= 1'b0;
      depth_q      <= '0;
      ack_o        <= 1'b0;
      x_o          <= '0;
      y_o          <= '0;
      z_o          <= '0;
      color_o      <= '0;
      u_o          <= '0;
      v_o          <= '0;
      a_o          <= '0;
      write_o      <= 1'b0;
      zr_request_o <= 1'b0;
      zr_addr_o    <= '0;
      zw_request_o <= 1'b0;
      zw_addr_o    <= '0;
      zw_data_o    <= '0;
      zw_sel_o     <= '0;
    end else begin
      ack_o <= 1'b0;
      case (state_q)
        ZB_WAIT: begin
          if (write_i) begin
            x_o     <= x_i;
            y_o     <= y_i;
            z_o     <= z_i;
            color_o <= color_i;
            u_o     <= u_i;
            v_o     <= v_i;
            a_o     <= a_i;
            state_q <= zbuf_enable_i ? ZB_ADDR : ZB_FORWARD;
          end
        end
        ZB_ADDR: begin
          zr_addr_o    <= {zaddr_d[31:2], 2'b00};
          zw_addr_o    <= {zaddr_d[31:2], 2'b00};
          half_q       <= zaddr_d[1];
          zr_request_o <= 1'b1;
          state_q      <= ZB_READ;
        end
        ZB_READ: begin
          if (zr_ack_i) begin
            zr_request_o <= 1'b0;
            depth_q      <= half_q ? zr_data_i[31:16] : zr_data_i[15:0];
            state_q      <= ZB_TEST;
          end
        end
        ZB_TEST: begin
          if (depth_pass(z_o[15:0], depth_q)) begin
            zw_request_o <= 1'b1;
            zw_data_o    <= {2{z_o[15:0]}};
            zw_sel_o     <= half_q ? 4'b1100 : 4'b0011;
            state_q      <= ZB_ZWRITE;
          end else begin
            ack_o   <= 1'b1;
            state_q <= ZB_DONE;
          end
        end
        ZB_ZWRITE: begin
          // Offer the pixel downstream in the same edge the depth write retires.
          if (zw_ack_i) begin
            zw_request_o <= 1'b0;
            write_o      <= 1'b1;
            state_q      <= ZB_FORWARD;
          end
        end
        ZB_FORWARD: begin
          // Bypass arrives here with write_o low and raises it one cycle later.
          if (!write_o) begin
            write_o <= 1'b1;
          end else if (ack_i) begin
            write_o <= 1'b0;
            ack_o   <= 1'b1;
            state_q <= ZB_DONE;
          end
        end
        ZB_DONE: begin
          state_q <= ZB_WAIT;
        end
        default: begin
          state_q <= ZB_WAIT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
